// File: rtl/tpu_pkg.sv
// Shared constants and types for the 2x2 systolic MMU datapath.
package tpu_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned N          = 2;
  localparam int unsigned ELEMS      = N * N;
  localparam int unsigned FEED_BEATS = 2 * N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

  // Flat operand-buffer index of element [row][col].
  function automatic logic [1:0] elem_idx(input logic row, input logic col);
    return {row, col};
  endfunction

endpackage

// File: rtl/mmu_feeder_skew.sv
// One-beat delay register that skews lane 1 behind lane 0 into the array.
module mmu_feeder_skew #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lane_i,
  output logic [DATA_W-1:0] lane_o
);

  logic [DATA_W-1:0] lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lane_q <= '0;
    else        lane_q <= lane_i;
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/mmu_feeder.sv
// Operand buffer, feed/drain sequencer and skewed operand streams for the 2x2 MMU.
module mmu_feeder #(
  parameter int unsigned DATA_W    = tpu_pkg::DATA_W,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic                               wr_sel,
  input  logic [1:0]                         wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               wr_ready,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic [tpu_pkg::N-1:0][DATA_W-1:0]  a_out,
  output logic [tpu_pkg::N-1:0][DATA_W-1:0]  b_out,
  output logic                               valid_out
);

  import tpu_pkg::*;

  localparam int unsigned BEAT_W  = $clog2(FEED_BEATS);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);

  feeder_state_t                  state_q, state_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [DRAIN_W-1:0]             drain_q, drain_d;
  logic [ELEMS-1:0][DATA_W-1:0]   buf_a_q, buf_b_q;
  logic                           wr_ready_q, wr_ready_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           valid_q, valid_d;
  logic [DATA_W-1:0]              a0_q, a0_d, a1_q, a1_d;
  logic [DATA_W-1:0]              b0_q, b0_d, b1_q, b1_d;
  logic [DATA_W-1:0]              a1_skew, b1_skew;
  logic                           feed_lane;
  logic                           k;

  // Operand buffer: writable only while idle, frozen during a sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else if (wr_en && wr_ready_q) begin
      if (wr_sel) buf_b_q[wr_addr] <= wr_data;
      else        buf_a_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      drain_q    <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      a0_q       <= '0;
      a1_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      drain_q    <= drain_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  end

  // Next state plus registered outputs derived from the upcoming state.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;

    unique case (state_q)
      IDLE: begin
        if (start && !wr_en) begin
          state_d = FEED;
          beat_d  = '0;
        end
      end
      FEED: begin
        if (beat_q == BEAT_W'(FEED_BEATS - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) state_d = IDLE;
        else                                    drain_d = drain_q + DRAIN_W'(1);
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    valid_d    = (state_d == FEED);
    done_d     = (state_d == DRAIN) && (drain_d == DRAIN_W'(DRAIN_CYC - 1));

    // Unskewed lane values for beat k; lane 1 is delayed afterwards by the skew regs.
    feed_lane = (state_d == FEED) && (beat_d < BEAT_W'(N));
    k         = beat_d[0];
    a0_d      = feed_lane ? buf_a_q[elem_idx(1'b0, k)] : '0;
    a1_d      = feed_lane ? buf_a_q[elem_idx(1'b1, k)] : '0;
    b0_d      = feed_lane ? buf_b_q[elem_idx(k, 1'b0)] : '0;
    b1_d      = feed_lane ? buf_b_q[elem_idx(k, 1'b1)] : '0;
  end

  mmu_feeder_skew #(.DATA_W(DATA_W)) u_skew_a1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .lane_i (a1_q),
    .lane_o (a1_skew)
  );

  mmu_feeder_skew #(.DATA_W(DATA_W)) u_skew_b1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .lane_i (b1_q),
    .lane_o (b1_skew)
  );

  assign wr_ready  = wr_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid_out = valid_q;
  assign a_out[0]  = a0_q;
  assign a_out[1]  = a1_skew;
  assign b_out[0]  = b0_q;
  assign b_out[1]  = b1_skew;

endmodule

// File: tb/tb_mmu_feeder.sv
// Self-checking bench for mmu_feeder against a skewed-stream reference model.
module tb_mmu_feeder;

  localparam int unsigned DW    = 8;
  localparam int unsigned DRAIN = 4;
  localparam int unsigned SEQ   = 3 + DRAIN;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en, wr_sel, start;
  logic [1:0]          wr_addr;
  logic [DW-1:0]       wr_data;
  logic                wr_ready, busy, done, valid_out;
  logic [1:0][DW-1:0]  a_out, b_out;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] ma [2][2];
  logic [DW-1:0] mb [2][2];
  int unsigned   obs_a [3][2];
  int unsigned   obs_b [3][2];

  always #5 clk = ~clk;

  mmu_feeder #(.DATA_W(DW), .DRAIN_CYC(DRAIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .a_out     (a_out),
    .b_out     (b_out),
    .valid_out (valid_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Row r of A enters lane r r beats late; column c of B enters lane c c beats late.
  function automatic logic [DW-1:0] exp_a(input int r, input int kk);
    int m;
    m = kk - r;
    if (m >= 0 && m < 2) return ma[r][m];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_b(input int c, input int kk);
    int m;
    m = kk - c;
    if (m >= 0 && m < 2) return mb[m][c];
    return '0;
  endfunction

  task automatic write_elem(input bit sel, input int r, input int c, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 2'(r * 2 + c);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
  endtask

  // Called on a negedge with the DUT idle; returns on the first idle cycle after done.
  task automatic feed_check(input string tag, input bit hold, input bit wr_mid);
    start = 1'b1;
    for (int c = 1; c <= int'(SEQ) + 1; c++) begin
      int kk;
      @(negedge clk);
      kk = c - 1;
      if (c == 1 && !hold) start = 1'b0;
      if (wr_mid && c == 1) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd9;
      end else if (wr_mid && c == 2) begin
        wr_en = 1'b0;
      end
      if (c <= int'(SEQ)) begin
        check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(1));
        check($sformatf("%s wr_ready c%0d", tag, c), 32'(wr_ready), 32'(0));
        check($sformatf("%s valid c%0d", tag, c), 32'(valid_out), 32'(kk < 3));
        check($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == int'(SEQ)));
        check($sformatf("%s a_out c%0d", tag, c), 32'(a_out), 32'({exp_a(1, kk), exp_a(0, kk)}));
        check($sformatf("%s b_out c%0d", tag, c), 32'(b_out), 32'({exp_b(1, kk), exp_b(0, kk)}));
        if (kk < 3) begin
          for (int l = 0; l < 2; l++) begin
            obs_a[kk][l] = 32'(a_out[l]);
            obs_b[kk][l] = 32'(b_out[l]);
          end
        end
      end else begin
        check($sformatf("%s idle busy", tag), 32'(busy), 32'(0));
        check($sformatf("%s idle wr_ready", tag), 32'(wr_ready), 32'(1));
        check($sformatf("%s idle valid", tag), 32'(valid_out), 32'(0));
        check($sformatf("%s idle done", tag), 32'(done), 32'(0));
      end
    end
  endtask

  // Output-stationary 2x2 array fed by the captured beats must yield A*B.
  task automatic check_product(input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        int unsigned got, want;
        got  = 0;
        want = 0;
        for (int t = 0; t < 5; t++) begin
          int ta, tb;
          ta = t - j;
          tb = t - i;
          if (ta >= 0 && ta < 3 && tb >= 0 && tb < 3) got += obs_a[ta][i] * obs_b[tb][j];
        end
        for (int m = 0; m < 2; m++) want += 32'(ma[i][m]) * 32'(mb[m][j]);
        check($sformatf("%s C[%0d][%0d]", tag, i, j), got, want);
      end
    end
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
      ma[r][c] = '0; mb[r][c] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset wr_ready", 32'(wr_ready), 32'(1));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset valid", 32'(valid_out), 32'(0));
    check("reset a_out", 32'(a_out), 32'(0));
    check("reset b_out", 32'(b_out), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operands A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) write_elem(1'b0, r, c, DW'(r * 2 + c + 1));
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) write_elem(1'b1, r, c, DW'(r * 2 + c + 5));
    feed_check("basic", 1'b0, 1'b0);
    check_product("basic");

    // Write during FEED is dropped; re-feed shows the original operand
    feed_check("wr_drop", 1'b0, 1'b1);
    feed_check("refeed", 1'b0, 1'b0);

    // Simultaneous start and write: write lands, start ignored
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd3; wr_data = 8'hA5;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    mb[1][1] = 8'hA5;
    check("start+wr busy", 32'(busy), 32'(0));
    check("start+wr wr_ready", 32'(wr_ready), 32'(1));
    check("start+wr valid", 32'(valid_out), 32'(0));
    feed_check("after_wr", 1'b0, 1'b0);

    // start held high: back-to-back sequences with one idle cycle between
    feed_check("hold0", 1'b1, 1'b0);
    feed_check("hold1", 1'b1, 1'b0);
    feed_check("hold2", 1'b0, 1'b0);

    // Async reset at FEED beat 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid valid", 32'(valid_out), 32'(0));
    check("rst_mid a_out", 32'(a_out), 32'(0));
    check("rst_mid b_out", 32'(b_out), 32'(0));
    check("rst_mid busy", 32'(busy), 32'(0));
    check("rst_mid wr_ready", 32'(wr_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("rst_mid no done", 32'(done_seen), 32'(0));
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
      ma[r][c] = '0; mb[r][c] = '0;
    end
    feed_check("cleared", 1'b0, 1'b0);

    // Randomized operands
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
        write_elem(1'b0, r, c, DW'($urandom));
        write_elem(1'b1, r, c, DW'($urandom));
      end
      feed_check($sformatf("rand%0d", it), 1'b0, 1'b0);
      check_product($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
